// File: rtl/arith_op_sequencer_pkg.sv
// Shared op codes, sequencer states and op classification helpers
// for the arithmetic instruction sequencer.
package arith_op_sequencer_pkg;

    localparam logic [2:0] OP_NULL  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_AND   = 3'd5;
    localparam logic [2:0] OP_LEFT4 = 3'd6;
    localparam logic [2:0] OP_LEFT3 = 3'd7;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_FETCH = 3'd1,
        SEQ_LOAD  = 3'd2,
        SEQ_START = 3'd3,
        SEQ_WAIT  = 3'd4,
        SEQ_STORE = 3'd5,
        SEQ_DONE  = 3'd6
    } seq_state_t;

    function automatic logic op_needs_operand(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_AND);
    endfunction

    function automatic logic op_is_shift(input logic [2:0] op);
        return (op == OP_LEFT4) || (op == OP_LEFT3);
    endfunction

endpackage

// File: rtl/arith_op_sequencer_watchdog.sv
// Cycle counter that flags expiry once TIMEOUT wait cycles elapse
// without the controller finishing.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import arith_op_sequencer_pkg::*;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] count;

    assign expired = (count == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/arith_op_sequencer.sv
// Issues one arithmetic instruction at a time: operand fetch, start,
// watchdog-guarded wait, optional write-back of reg C, done pulse.
module arith_op_sequencer
    import arith_op_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 31,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_store,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] reg_c,
    output logic [DATA_W-1:0] operand,
    output logic              do_read_mem,
    output logic              mem_read_sign,
    output logic              arith_start,
    output logic [2:0]        arith_operation,
    input  logic              arith_finish,
    output logic              busy,
    output logic              done,
    output logic              error
);

    seq_state_t state;
    seq_state_t nxt;
    logic [2:0] op_q;
    logic       store_q;
    logic       accept;
    logic       expired;
    logic       abort;
    logic [2:0] op_cur;

    assign accept        = instr_valid & instr_ready;
    assign mem_read_sign = operand[DATA_W-1];
    // A shift op enters START straight from IDLE, before op_q is loaded.
    assign op_cur        = (state == SEQ_IDLE) ? instr_op : op_q;

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == SEQ_START),
        .enable  (state == SEQ_WAIT),
        .expired (expired)
    );

    always_comb begin
        nxt   = state;
        abort = 1'b0;
        unique case (state)
            SEQ_IDLE: begin
                if (accept) begin
                    if (op_needs_operand(instr_op)) begin
                        nxt = SEQ_FETCH;
                    end else if (op_is_shift(instr_op)) begin
                        nxt = SEQ_START;
                    end else begin
                        nxt = SEQ_DONE;
                    end
                end
            end
            SEQ_FETCH: if (mem_ack) nxt = SEQ_LOAD;
            SEQ_LOAD:  nxt = SEQ_START;
            SEQ_START: nxt = SEQ_WAIT;
            SEQ_WAIT: begin
                // finish takes priority over a same-cycle expiry
                if (arith_finish) begin
                    nxt = store_q ? SEQ_STORE : SEQ_DONE;
                end else if (expired) begin
                    nxt   = SEQ_DONE;
                    abort = 1'b1;
                end
            end
            SEQ_STORE: if (mem_ack) nxt = SEQ_DONE;
            SEQ_DONE:  nxt = SEQ_IDLE;
            default:   nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= SEQ_IDLE;
            op_q            <= OP_NULL;
            store_q         <= 1'b0;
            instr_ready     <= 1'b1;
            busy            <= 1'b0;
            mem_rd_req      <= 1'b0;
            mem_wr_req      <= 1'b0;
            do_read_mem     <= 1'b0;
            arith_start     <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            arith_operation <= OP_NULL;
            mem_addr        <= '0;
            operand         <= '0;
            mem_wdata       <= '0;
        end else begin
            state       <= nxt;
            instr_ready <= (nxt == SEQ_IDLE);
            busy        <= (nxt != SEQ_IDLE);
            mem_rd_req  <= (nxt == SEQ_FETCH);
            mem_wr_req  <= (nxt == SEQ_STORE);
            do_read_mem <= (nxt == SEQ_LOAD);
            arith_start <= (nxt == SEQ_START);
            done        <= (nxt == SEQ_DONE);
            if (nxt == SEQ_START || nxt == SEQ_WAIT) begin
                arith_operation <= op_cur;
            end else begin
                arith_operation <= OP_NULL;
            end
            if (accept) begin
                op_q     <= instr_op;
                store_q  <= instr_store;
                mem_addr <= instr_addr;
                error    <= 1'b0;
            end
            if (state == SEQ_FETCH && mem_ack) begin
                operand <= mem_rdata;
            end
            if (state == SEQ_WAIT && arith_finish) begin
                mem_wdata <= reg_c;
            end
            if (abort) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Scoreboarded bench for arith_op_sequencer with memory and
// controller responders.
module tb_arith_op_sequencer;

    localparam int AW = 12;
    localparam int DW = 31;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_op;
    logic [AW-1:0] instr_addr;
    logic          instr_store;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] reg_c;
    logic [DW-1:0] operand;
    logic          do_read_mem;
    logic          mem_read_sign;
    logic          arith_start;
    logic [2:0]    arith_operation;
    logic          arith_finish;
    logic          busy;
    logic          done;
    logic          error;

    arith_op_sequencer #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_op        (instr_op),
        .instr_addr      (instr_addr),
        .instr_store     (instr_store),
        .mem_addr        (mem_addr),
        .mem_rd_req      (mem_rd_req),
        .mem_wr_req      (mem_wr_req),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .mem_wdata       (mem_wdata),
        .reg_c           (reg_c),
        .operand         (operand),
        .do_read_mem     (do_read_mem),
        .mem_read_sign   (mem_read_sign),
        .arith_start     (arith_start),
        .arith_operation (arith_operation),
        .arith_finish    (arith_finish),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] opnd;
        logic [DW-1:0] wdata;
        logic          err;
        int            rd;
        int            wr;
        int            starts;
        int            lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int errors = 0;
    int checks = 0;

    int ack_delay = 0;
    int fin_delay = -1;
    int ack_cnt   = 0;
    int fin_cnt   = 0;

    int            rd_rises, wr_rises, rd_cycles, wr_cycles;
    int            start_cnt, load_cnt, done_cnt, both_cnt;
    logic          prev_rd = 1'b0;
    logic          prev_wr = 1'b0;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [DW-1:0] opnd_o, wd_o;
    logic          sign_o;
    logic [2:0]    start_op_o;

    bit got;
    int lat;

    // memory: ack after ack_delay cycles of a held request
    always @(negedge clk) begin
        if (mem_rd_req || mem_wr_req) begin
            if (ack_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                ack_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end
    end

    // controller: finish fin_delay cycles after start, never if negative
    always @(negedge clk) begin
        arith_finish = 1'b0;
        if (arith_start) begin
            fin_cnt = fin_delay;
        end else if (fin_cnt > 0) begin
            fin_cnt--;
            if (fin_cnt == 0) arith_finish = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mem_rd_req && !prev_rd) begin
            rd_rises++;
            rd_addr_o = mem_addr;
        end
        if (mem_wr_req && !prev_wr) begin
            wr_rises++;
            wr_addr_o = mem_addr;
            wd_o      = mem_wdata;
        end
        if (mem_rd_req) rd_cycles++;
        if (mem_wr_req) wr_cycles++;
        if (mem_rd_req && mem_wr_req) both_cnt++;
        if (do_read_mem) begin
            load_cnt++;
            opnd_o = operand;
            sign_o = mem_read_sign;
        end
        if (arith_start) begin
            start_cnt++;
            start_op_o = arith_operation;
        end
        if (done) done_cnt++;
        prev_rd = mem_rd_req;
        prev_wr = mem_wr_req;
    end

    task automatic clear_obs();
        rd_rises  = 0;
        wr_rises  = 0;
        rd_cycles = 0;
        wr_cycles = 0;
        start_cnt = 0;
        load_cnt  = 0;
        done_cnt  = 0;
        opnd_o    = '0;
        wd_o      = '0;
        sign_o    = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic st);
        for (int i = 0; i < 100 && !instr_ready; i++) @(negedge clk);
        @(negedge clk);
        #1;
        clear_obs();
        instr_valid = 1'b1;
        instr_op    = op;
        instr_addr  = addr;
        instr_store = st;
        @(negedge clk);
        instr_valid = 1'b0;
        got = 0;
        lat = 0;
        for (int i = 1; i <= 200 && !got; i++) begin
            if (done) begin
                got = 1;
                lat = i;
            end else begin
                @(negedge clk);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got ready=%b busy=%b want 1 0",
                     instr_ready, busy);
        end
        checks++;
        if (arith_operation !== 3'd0) begin
            errors++;
            $display("FAIL reset_op: got %0d want 0", arith_operation);
        end
        checks++;
        if ({mem_rd_req, mem_wr_req, arith_start, do_read_mem, done, error}
            !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 000000",
                     {mem_rd_req, mem_wr_req, arith_start, do_read_mem,
                      done, error});
        end
        checks++;
        if (mem_addr !== '0 || operand !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_latches: got %h %h %h want 0",
                     mem_addr, operand, mem_wdata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fetch_op();
        ack_delay = 0;
        fin_delay = 3;
        mem_rdata = 31'h4000_0005;
        sb.push_back('{op: 3'd5, addr: 12'h123, opnd: 31'h4000_0005,
                      wdata: '0, err: 1'b0, rd: 1, wr: 0, starts: 1, lat: 7});
        issue(3'd5, 12'h123, 1'b0);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++;
            $display("FAIL and_latency: got done=%0d lat=%0d want %0d",
                     got, lat, e.lat);
        end
        checks++;
        if (rd_rises != e.rd || rd_addr_o !== e.addr) begin
            errors++;
            $display("FAIL and_read: got %0d @%h want %0d @%h",
                     rd_rises, rd_addr_o, e.rd, e.addr);
        end
        checks++;
        if (load_cnt != 1 || opnd_o !== e.opnd || sign_o !== 1'b1) begin
            errors++;
            $display("FAIL and_load: got n=%0d opnd=%h sign=%b want 1 %h 1",
                     load_cnt, opnd_o, sign_o, e.opnd);
        end
        checks++;
        if (start_cnt != e.starts || start_op_o !== e.op) begin
            errors++;
            $display("FAIL and_start: got n=%0d op=%0d want %0d op=%0d",
                     start_cnt, start_op_o, e.starts, e.op);
        end
        checks++;
        if (wr_rises != e.wr || error !== e.err) begin
            errors++;
            $display("FAIL and_nostore: got wr=%0d err=%b want %0d %b",
                     wr_rises, error, e.wr, e.err);
        end
    endtask

    task automatic test_shift_store();
        ack_delay = 0;
        fin_delay = 2;
        reg_c     = 31'h0000_0038;
        sb.push_back('{op: 3'd7, addr: 12'h2a4, opnd: '0,
                      wdata: 31'h38, err: 1'b0, rd: 0, wr: 1, starts: 1, lat: 5});
        issue(3'd7, 12'h2a4, 1'b1);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++;
            $display("FAIL shift_latency: got done=%0d lat=%0d want %0d",
                     got, lat, e.lat);
        end
        checks++;
        if (rd_rises != e.rd || load_cnt != 0) begin
            errors++;
            $display("FAIL shift_noread: got rd=%0d load=%0d want 0 0",
                     rd_rises, load_cnt);
        end
        checks++;
        if (start_cnt != e.starts || start_op_o !== e.op) begin
            errors++;
            $display("FAIL shift_start: got n=%0d op=%0d want %0d op=%0d",
                     start_cnt, start_op_o, e.starts, e.op);
        end
        checks++;
        if (wr_rises != e.wr || wd_o !== e.wdata || wr_addr_o !== e.addr) begin
            errors++;
            $display("FAIL shift_store: got n=%0d %h @%h want %0d %h @%h",
                     wr_rises, wd_o, wr_addr_o, e.wr, e.wdata, e.addr);
        end
    endtask

    task automatic test_null();
        sb.push_back('{op: 3'd0, addr: 12'hfff, opnd: '0,
                      wdata: '0, err: 1'b0, rd: 0, wr: 0, starts: 0, lat: 1});
        issue(3'd0, 12'hfff, 1'b1);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++;
            $display("FAIL null_latency: got done=%0d lat=%0d want %0d",
                     got, lat, e.lat);
        end
        checks++;
        if (start_cnt != e.starts || rd_rises != e.rd || wr_rises != e.wr) begin
            errors++;
            $display("FAIL null_quiet: got st=%0d rd=%0d wr=%0d want 0 0 0",
                     start_cnt, rd_rises, wr_rises);
        end
    endtask

    task automatic test_ack_delay();
        ack_delay = 4;
        fin_delay = 1;
        mem_rdata = 31'h0123_4567;
        reg_c     = 31'h7654_3210;
        sb.push_back('{op: 3'd1, addr: 12'h0a5, opnd: 31'h0123_4567,
                      wdata: 31'h7654_3210, err: 1'b0, rd: 1, wr: 1,
                      starts: 1, lat: 14});
        issue(3'd1, 12'h0a5, 1'b1);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++;
            $display("FAIL slow_latency: got done=%0d lat=%0d want %0d",
                     got, lat, e.lat);
        end
        checks++;
        if (rd_rises != e.rd || rd_cycles != 5 || opnd_o !== e.opnd) begin
            errors++;
            $display("FAIL slow_read: got n=%0d cyc=%0d %h want 1 5 %h",
                     rd_rises, rd_cycles, opnd_o, e.opnd);
        end
        checks++;
        if (wr_rises != e.wr || wr_cycles != 5 || wd_o !== e.wdata) begin
            errors++;
            $display("FAIL slow_write: got n=%0d cyc=%0d %h want 1 5 %h",
                     wr_rises, wr_cycles, wd_o, e.wdata);
        end
        checks++;
        if (load_cnt != 1 || start_cnt != 1 || done_cnt != 1 || both_cnt != 0) begin
            errors++;
            $display("FAIL slow_pulses: got ld=%0d st=%0d dn=%0d both=%0d want 1 1 1 0",
                     load_cnt, start_cnt, done_cnt, both_cnt);
        end
        ack_delay = 0;
    endtask

    task automatic test_timeout();
        fin_delay = -1;
        mem_rdata = 31'h0000_0011;
        sb.push_back('{op: 3'd3, addr: 12'h050, opnd: 31'h11,
                      wdata: '0, err: 1'b1, rd: 1, wr: 0, starts: 1, lat: 13});
        issue(3'd3, 12'h050, 1'b1);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++;
            $display("FAIL tmo_latency: got done=%0d lat=%0d want %0d",
                     got, lat, e.lat);
        end
        checks++;
        if (error !== e.err || arith_operation !== 3'd0) begin
            errors++;
            $display("FAIL tmo_error: got err=%b op=%0d want 1 0",
                     error, arith_operation);
        end
        checks++;
        if (wr_rises != e.wr || start_cnt != e.starts) begin
            errors++;
            $display("FAIL tmo_nostore: got wr=%0d st=%0d want 0 1",
                     wr_rises, start_cnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: got %b want 1", error);
        end
        issue(3'd0, 12'h000, 1'b0);
        checks++;
        if (!got || error !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear: got done=%0d err=%b want 1 0", got, error);
        end
    endtask

    task automatic test_reset_mid();
        fin_delay = 6;
        @(negedge clk);
        #1;
        instr_valid = 1'b1;
        instr_op    = 3'd6;
        instr_addr  = 12'h321;
        instr_store = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || arith_operation !== 3'd6) begin
            errors++;
            $display("FAIL mid_wait: got busy=%b op=%0d want 1 6",
                     busy, arith_operation);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || instr_ready !== 1'b1 || arith_operation !== 3'd0 ||
            done !== 1'b0 || arith_start !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b rdy=%b op=%0d done=%b addr=%h want 0 1 0 0 0",
                     busy, instr_ready, arith_operation, done, mem_addr);
        end
        @(negedge clk);
        #1;
        clear_obs();
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || start_cnt != 0 || wr_rises != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_late_finish: got dn=%0d st=%0d wr=%0d busy=%b want 0 0 0 0",
                     done_cnt, start_cnt, wr_rises, busy);
        end
    endtask

    initial begin
        reset        = 1'b1;
        instr_valid  = 1'b0;
        instr_op     = 3'd0;
        instr_addr   = '0;
        instr_store  = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        reg_c        = '0;
        arith_finish = 1'b0;
        clear_obs();
        both_cnt     = 0;
        test_reset();
        test_fetch_op();
        test_shift_store();
        test_null();
        test_ack_delay();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
